// File: rtl/fdct_8x8_seq.sv
// Sequential 8x8 forward DCT: row pass into a transpose buffer, column pass out one column per beat.
// Define FDCT_PINGPONG_EN for two transpose buffers so filling one overlaps draining the other.
module fdct_8x8_seq #(
    parameter int unsigned IN_W  = 12,
    parameter int unsigned OUT_W = 12,
    parameter int unsigned ACC_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*IN_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*OUT_W-1:0] out_data,
    output logic [2:0]         out_idx,
    output logic               out_last
);

`ifdef FDCT_PINGPONG_EN
    localparam logic PingPong = 1'b1;
`else
    localparam logic PingPong = 1'b0;
`endif

    localparam int unsigned Y_W = 20;
    localparam logic signed [ACC_W-1:0] SatMax = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SatMin = ~SatMax;

    typedef enum logic {StFill, StDrain} state_e;

    // One state per buffer; without ping-pong both selects stay at 0 and buffer 1 is never used.
    state_e                state_q [2];
    state_e                state_d [2];
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [2:0]            row_q, row_d;
    logic [2:0]            col_q, col_d;
    logic signed [Y_W-1:0] buf_q [2][8][8];

    logic signed [IN_W-1:0]  in_lane [8];
    logic signed [Y_W-1:0]   row_y [8];
    logic signed [ACC_W-1:0] row_acc;
    logic signed [ACC_W-1:0] col_acc;
    logic signed [ACC_W-1:0] col_sh;
    logic                    in_fire;
    logic                    out_fire;

    // C[k][n] = round(2048 * 2 * s(k) * cos((2n+1) k pi / 16)), folded onto the first quadrant.
    function automatic logic signed [15:0] coef(input int k, input int n);
        int m;
        int mag;
        if (k == 0) begin
            return 16'sd1448;
        end
        m = ((2 * n + 1) * k) % 32;
        if (m > 16) begin
            m = 32 - m;
        end
        case ((m > 8) ? (16 - m) : m)
            1: mag = 2009;
            2: mag = 1892;
            3: mag = 1703;
            4: mag = 1448;
            5: mag = 1138;
            6: mag = 784;
            7: mag = 400;
            default: mag = 0;
        endcase
        return (m > 8) ? -16'(mag) : 16'(mag);
    endfunction

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            in_lane[n] = in_data[n*IN_W +: IN_W];
        end
    end

    always_comb begin
        row_acc = '0;
        for (int k = 0; k < 8; k++) begin
            row_acc = ACC_W'(256);
            for (int n = 0; n < 8; n++) begin
                row_acc = row_acc + ACC_W'(in_lane[n]) * ACC_W'(coef(k, n));
            end
            row_y[k] = Y_W'(row_acc >>> 9);
        end
    end

    always_comb begin
        col_acc  = '0;
        col_sh   = '0;
        out_data = '0;
        for (int u = 0; u < 8; u++) begin
            col_acc = ACC_W'(16384);
            for (int r = 0; r < 8; r++) begin
                col_acc = col_acc + ACC_W'(coef(u, r)) * ACC_W'(buf_q[rd_sel_q][r][col_q]);
            end
            col_sh = col_acc >>> 15;
            if (col_sh > SatMax) begin
                out_data[u*OUT_W +: OUT_W] = SatMax[OUT_W-1:0];
            end else if (col_sh < SatMin) begin
                out_data[u*OUT_W +: OUT_W] = SatMin[OUT_W-1:0];
            end else begin
                out_data[u*OUT_W +: OUT_W] = col_sh[OUT_W-1:0];
            end
        end
    end

    always_comb begin
        in_ready  = (state_q[wr_sel_q] == StFill);
        out_valid = (state_q[rd_sel_q] == StDrain);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        out_idx   = col_q;
        out_last  = out_valid && (col_q == 3'd7);
    end

    always_comb begin
        state_d  = state_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        row_d    = row_q;
        col_d    = col_q;
        if (in_fire) begin
            row_d = row_q + 3'd1;
            if (row_q == 3'd7) begin
                state_d[wr_sel_q] = StDrain;
                wr_sel_d          = wr_sel_q ^ PingPong;
            end
        end
        // Fill and drain never target the same buffer in one cycle.
        if (out_fire) begin
            col_d = col_q + 3'd1;
            if (col_q == 3'd7) begin
                state_d[rd_sel_q] = StFill;
                rd_sel_d          = rd_sel_q ^ PingPong;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q[0] <= StFill;
            state_q[1] <= StFill;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
        end else begin
            state_q  <= state_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

    always_ff @(posedge clock) begin
        if (in_fire) begin
            for (int k = 0; k < 8; k++) begin
                buf_q[wr_sel_q][row_q][k] <= row_y[k];
            end
        end
    end

endmodule

// File: tb/tb_fdct_8x8_seq.sv
// Self-checking bench for fdct_8x8_seq against a real-valued-cosine integer reference model.
// Honours FDCT_PINGPONG_EN for the back-to-back throughput expectations.
module tb_fdct_8x8_seq;

    localparam int IN_W  = 12;
    localparam int OUT_W = 12;
`ifdef FDCT_PINGPONG_EN
    localparam bit PING = 1'b1;
`else
    localparam bit PING = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [8*IN_W-1:0]  in_data;
    logic               out_valid;
    logic               out_ready;
    logic [8*OUT_W-1:0] out_data;
    logic [2:0]         out_idx;
    logic               out_last;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int ctab [8][8];
    int sx [4][8][8];
    int sf [4][8][8];
    int got [8][8];

    fdct_8x8_seq dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic build_table();
        real s;
        real v;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                s = (k == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
                v = 2048.0 * 2.0 * s * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
                ctab[k][n] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
            end
        end
    endtask

    task automatic model(input int b);
        longint y [8][8];
        longint acc;
        longint f;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
                acc = 256;
                for (int n = 0; n < 8; n++) acc += longint'(sx[b][r][n]) * ctab[k][n];
                y[r][k] = acc >>> 9;
            end
        end
        for (int u = 0; u < 8; u++) begin
            for (int c = 0; c < 8; c++) begin
                acc = 16384;
                for (int r = 0; r < 8; r++) acc += longint'(ctab[u][r]) * y[r][c];
                f = acc >>> 15;
                if (f > 2047) f = 2047;
                if (f < -2048) f = -2048;
                sf[b][u][c] = int'(f);
            end
        end
    endtask

    function automatic logic [8*IN_W-1:0] pack(input int b, input int r);
        int v;
        logic [8*IN_W-1:0] d;
        d = '0;
        for (int n = 0; n < 8; n++) begin
            v = sx[b][r][n];
            d[n*IN_W +: IN_W] = v[IN_W-1:0];
        end
        return d;
    endfunction

    function automatic int lane(input logic [8*OUT_W-1:0] d, input int u);
        logic signed [OUT_W-1:0] s;
        s = d[u*OUT_W +: OUT_W];
        return int'(s);
    endfunction

    task automatic fill_block(input int b, input bit gaps);
        int r = 0;
        int cyc = 0;
        bit early = 1'b0;
        bit v;
        bit fire;
        while (r < 8 && cyc < 200) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid = v;
            in_data  = pack(b, r);
            if (out_valid) early = 1'b1;
            fire = v && in_ready;
            @(posedge clock); #1;
            cyc++;
            if (fire) r++;
        end
        in_valid = 1'b0;
        checks++;
        if (r != 8) begin
            errors++; $display("FAIL fill_rows: got %0d rows accepted, expected 8", r);
        end
        checks++;
        if (early) begin
            errors++; $display("FAIL early_out_valid: got out_valid=1 during fill, expected 0");
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL latency: got out_valid=%b after 8th row, expected 1", out_valid);
        end
    endtask

    task automatic drain_block(input int b, input bit rand_ready, input bit junk);
        int c = 0;
        int cyc = 0;
        int bad_u;
        bit stalled = 1'b0;
        logic [8*OUT_W-1:0] pd;
        logic [2:0] pidx;
        while (c < 8 && cyc < 300) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (junk) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom};
            end
            if (stalled) begin
                checks++;
                if (out_data !== pd || out_idx !== pidx) begin
                    errors++;
                    $display("FAIL stall_stable: got idx %0d data %h, expected idx %0d data %h",
                             out_idx, out_data, pidx, pd);
                end
            end
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                checks++;
                if (out_idx !== c[2:0]) begin
                    errors++; $display("FAIL out_idx: got %0d, expected %0d", out_idx, c);
                end
                checks++;
                if (out_last !== (c == 7)) begin
                    errors++; $display("FAIL out_last: got %b at beat %0d, expected %b",
                                       out_last, c, (c == 7));
                end
                bad_u = -1;
                for (int u = 0; u < 8; u++) begin
                    got[u][c] = lane(out_data, u);
                    if (got[u][c] != sf[b][u][c] && bad_u < 0) bad_u = u;
                end
                checks++;
                if (bad_u >= 0) begin
                    errors++;
                    $display("FAIL coef F[%0d][%0d]: got %0d, expected %0d",
                             bad_u, c, got[bad_u][c], sf[b][bad_u][c]);
                end
                c++;
            end else if (out_valid) begin
                stalled = 1'b1;
                pd      = out_data;
                pidx    = out_idx;
            end
            @(posedge clock); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (c != 8) begin
            errors++; $display("FAIL drain_beats: got %0d beats, expected 8", c);
        end
    endtask

    task automatic check_dc_only(input string name, input int dc);
        bit ok = (got[0][0] == dc);
        for (int u = 0; u < 8; u++)
            for (int c = 0; c < 8; c++)
                if ((u != 0 || c != 0) && got[u][c] != 0) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++; $display("FAIL %s: got F00=%0d, expected %0d with all AC zero",
                               name, got[0][0], dc);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_held: got out_valid=%b in_ready=%b, expected 0/1",
                               out_valid, in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b vld=%b idx=%0d last=%b, expected 1 0 0 0",
                     in_ready, out_valid, out_idx, out_last);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_dc(input int val, input int dc);
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++) sx[0][r][n] = val;
        model(0);
        fill_block(0, 1'b0);
        drain_block(0, 1'b0, 1'b0);
        check_dc_only($sformatf("dc_%0d", val), dc);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL back_to_fill: got rdy=%b vld=%b, expected 1/0",
                               in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        for (int blk = 0; blk < 3; blk++) begin
            for (int r = 0; r < 8; r++)
                for (int n = 0; n < 8; n++) sx[0][r][n] = int'($urandom_range(0, 511)) - 256;
            model(0);
            fill_block(0, 1'b1);
            drain_block(0, 1'b1, !PING);
        end
    endtask

    task automatic test_reset_midblock();
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++) sx[0][r][n] = int'($urandom_range(0, 511)) - 256;
        for (int r = 0; r < 5; r++) begin
            in_valid = 1'b1;
            in_data  = pack(0, r);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 3'd0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL midblock_reset: got rdy=%b vld=%b idx=%0d last=%b, expected 1 0 0 0",
                     in_ready, out_valid, out_idx, out_last);
        end
        for (int r = 0; r < 8; r++)
            for (int n = 0; n < 8; n++) sx[0][r][n] = 100;
        model(0);
        fill_block(0, 1'b0);
        drain_block(0, 1'b0, 1'b0);
        check_dc_only("midblock_dc_100", 800);
    endtask

    task automatic test_back_to_back();
        int drops = 0;
        int beats = 0;
        int last_t [4];
        for (int b = 0; b < 4; b++) begin
            last_t[b] = 0;
            for (int r = 0; r < 8; r++)
                for (int n = 0; n < 8; n++) sx[b][r][n] = int'($urandom_range(0, 511)) - 256;
            model(b);
        end
        fork
            begin
                int cyc = 0;
                bit fire;
                for (int b = 0; b < 4; b++) begin
                    for (int r = 0; r < 8; r++) begin
                        in_valid = 1'b1;
                        in_data  = pack(b, r);
                        fire     = 1'b0;
                        while (!fire && cyc < 400) begin
                            fire = in_ready;
                            if (!in_ready) drops++;
                            @(posedge clock); #1;
                            cyc++;
                        end
                    end
                end
                in_valid = 1'b0;
            end
            begin
                int cyc = 0;
                int bad_u;
                out_ready = 1'b1;
                while (beats < 32 && cyc < 500) begin
                    if (out_valid) begin
                        bad_u = -1;
                        for (int u = 0; u < 8; u++)
                            if (lane(out_data, u) != sf[beats / 8][u][beats % 8] && bad_u < 0)
                                bad_u = u;
                        checks++;
                        if (bad_u >= 0 || out_idx !== 3'(beats % 8)) begin
                            errors++;
                            $display("FAIL stream_beat %0d: got idx %0d lane%0d=%0d, expected idx %0d",
                                     beats, out_idx, (bad_u < 0) ? 0 : bad_u,
                                     lane(out_data, (bad_u < 0) ? 0 : bad_u), beats % 8);
                        end
                        if (out_last) last_t[beats / 8] = cyc_cnt;
                        beats++;
                    end
                    @(posedge clock); #1;
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        checks++;
        if (beats != 32) begin
            errors++; $display("FAIL stream_beats: got %0d, expected 32", beats);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (last_t[i] - last_t[i-1] != (PING ? 8 : 16)) begin
                errors++; $display("FAIL block_interval %0d: got %0d cycles, expected %0d",
                                   i, last_t[i] - last_t[i-1], PING ? 8 : 16);
            end
        end
        if (PING) begin
            checks++;
            if (drops != 0) begin
                errors++; $display("FAIL in_ready_drop: got %0d stalled cycles, expected 0", drops);
            end
        end
    endtask

    initial begin
        build_table();
        test_reset();
        test_dc(100, 800);
        test_dc(255, 2039);
        test_dc(-256, -2048);
        test_dc(2047, 2047);
        test_random();
        test_reset_midblock();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
